io_port_bank: RTL and testbench

//   Parametrised memory-mapped I/O bank for the simple CPU. Replaces the fixed pair of 8-bit LED

---
 rtl/io_port_pkg.sv | 25 ++
 rtl/io_debounce.sv | 51 +++++
 rtl/io_port_bank.sv | 111 +++++++++++
 tb/tb_io_port_bank.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// Shared constants and register-map helpers for the I/O port bank.
package io_port_pkg;

  localparam int unsigned DefNumPorts = 2;
  localparam int unsigned DefPortW    = 8;
  localparam int unsigned DefDebCycles = 4;
  localparam int unsigned DefAddrW    = 4;

  function automatic int unsigned out_base();
    return 0;
  endfunction

  function automatic int unsigned in_base(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned status_addr(input int unsigned n);
    return 2 * n;
  endfunction

  function automatic int unsigned mask_addr(input int unsigned n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus stability counter for one input port; emits a
// one-cycle changed pulse on the edge the debounced value updates.
module io_debounce #(
  parameter int unsigned PORT_W     = 8,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [PORT_W-1:0] raw,
  output logic [PORT_W-1:0] deb,
  output logic              changed
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES) + 1;

  logic [PORT_W-1:0] sync1_q, sync2_q, deb_q, deb_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // sync1 != sync2 means the synced value is about to change; restart the count.
  always_comb begin
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    changed = 1'b0;
    if ((sync1_q != sync2_q) || (sync2_q == deb_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
      cnt_d   = '0;
      deb_d   = sync2_q;
      changed = 1'b1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped bank of output registers and debounced inputs with sticky change flags.
// Define IO_PORT_BANK_IRQ_EN to implement the MASK register and the registered irq output.
module io_port_bank
  import io_port_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = DefNumPorts,
  parameter int unsigned PORT_W     = DefPortW,
  parameter int unsigned DEB_CYCLES = DefDebCycles,
  parameter int unsigned ADDR_W     = DefAddrW
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [PORT_W-1:0]           wdata,
  input  logic                        wr_en,
  input  logic                        rd_en,
  output logic [PORT_W-1:0]           rdata,
  output logic                        rvalid,
  input  logic [NUM_PORTS*PORT_W-1:0] sw_in,
  output logic [NUM_PORTS*PORT_W-1:0] led_out,
  output logic                        irq
);

  logic [NUM_PORTS-1:0][PORT_W-1:0] out_q, out_d;
  logic [NUM_PORTS-1:0][PORT_W-1:0] in_val;
  logic [NUM_PORTS-1:0]             changed;
  logic [NUM_PORTS-1:0]             status_q, status_d, status_clr;
  logic [PORT_W-1:0]                rdata_q, rd_mux;
  logic                             rvalid_q;
  logic                             sel_status, sel_mask;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_in
    io_debounce #(
      .PORT_W    (PORT_W),
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clock  (clock),
      .rst    (rst),
      .raw    (sw_in[k*PORT_W +: PORT_W]),
      .deb    (in_val[k]),
      .changed(changed[k])
    );
  end

  assign sel_status = (addr == ADDR_W'(status_addr(NUM_PORTS)));
  assign sel_mask   = (addr == ADDR_W'(mask_addr(NUM_PORTS)));

`ifdef IO_PORT_BANK_IRQ_EN
  logic [NUM_PORTS-1:0] mask_q, mask_d;
  logic                 irq_q;

  assign mask_d = (wr_en && sel_mask) ? wdata[NUM_PORTS-1:0] : mask_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= |(status_q & mask_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux sees pre-write state, so a same-cycle write does not bypass into rdata.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (addr == ADDR_W'(out_base() + k)) rd_mux = out_q[k];
      if (addr == ADDR_W'(in_base(NUM_PORTS) + k)) rd_mux = in_val[k];
    end
    if (sel_status) rd_mux = PORT_W'(status_q);
`ifdef IO_PORT_BANK_IRQ_EN
    if (sel_mask) rd_mux = PORT_W'(mask_q);
`endif
  end

  always_comb begin
    out_d = out_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (wr_en && (addr == ADDR_W'(out_base() + k))) out_d[k] = wdata;
    end
  end

  // Set beats write-1-clear on the same bit.
  assign status_clr = (wr_en && sel_status) ? wdata[NUM_PORTS-1:0] : '0;
  assign status_d   = (status_q & ~status_clr) | changed;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      status_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      status_q <= status_d;
      rvalid_q <= rd_en;
      if (rd_en) rdata_q <= rd_mux;
    end
  end

  assign led_out = out_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed, table-driven bench for io_port_bank (N=2, W=8, DEB=4); honours IO_PORT_BANK_IRQ_EN.
module tb_io_port_bank;

  logic        clock;
  logic        rst;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        irq;

  int checks;
  int errors;

  io_port_bank #(
    .NUM_PORTS (2),
    .PORT_W    (8),
    .DEB_CYCLES(4),
    .ADDR_W    (4)
  ) dut (
    .clock  (clock),
    .rst    (rst),
    .addr   (addr),
    .wdata  (wdata),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .rdata  (rdata),
    .rvalid (rvalid),
    .sw_in  (sw_in),
    .led_out(led_out),
    .irq    (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic        wr;
    logic        rd;
    logic [7:0]  exp_rdata;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [7:0] exp);
    addr  = a;
    rd_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rd_en = 1'b0;
    check({name, " rvalid"}, 32'(rvalid), 32'd1);
    check(name, 32'(rdata), 32'(exp));
  endtask

  task automatic apply(input vec_t v, input int idx);
    addr  = v.addr;
    wdata = v.wdata;
    wr_en = v.wr;
    rd_en = v.rd;
    @(posedge clock);
    @(negedge clock);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check($sformatf("vec%0d led_out", idx), 32'(led_out), 32'(v.exp_led));
    check($sformatf("vec%0d rvalid", idx), 32'(rvalid), 32'(v.rd));
    if (v.rd) check($sformatf("vec%0d rdata", idx), 32'(rdata), 32'(v.exp_rdata));
  endtask

  initial begin
    logic [7:0] mask_exp;
    logic [7:0] last_rd;
    checks = 0;
    errors = 0;
`ifdef IO_PORT_BANK_IRQ_EN
    mask_exp = 8'h03;
`else
    mask_exp = 8'h00;
`endif

    //             addr   wdata  wr    rd    rdata  led
    vecs[0]  = '{4'd1,  8'hA5, 1'b1, 1'b0, 8'h00, 16'hA500};
    vecs[1]  = '{4'd1,  8'h00, 1'b0, 1'b1, 8'hA5, 16'hA500};
    vecs[2]  = '{4'd0,  8'h5A, 1'b1, 1'b0, 8'h00, 16'hA55A};
    vecs[3]  = '{4'd0,  8'h77, 1'b1, 1'b1, 8'h5A, 16'hA577};
    vecs[4]  = '{4'd0,  8'h00, 1'b0, 1'b1, 8'h77, 16'hA577};
    vecs[5]  = '{4'd7,  8'h00, 1'b0, 1'b1, 8'h00, 16'hA577};
    vecs[6]  = '{4'd3,  8'hFF, 1'b1, 1'b0, 8'h00, 16'hA577};
    vecs[7]  = '{4'd3,  8'h00, 1'b0, 1'b1, 8'h00, 16'hA577};
    vecs[8]  = '{4'd4,  8'h00, 1'b0, 1'b1, 8'h00, 16'hA577};
    vecs[9]  = '{4'd15, 8'h12, 1'b1, 1'b0, 8'h00, 16'hA577};
    vecs[10] = '{4'd15, 8'h00, 1'b0, 1'b1, 8'h00, 16'hA577};
    vecs[11] = '{4'd5,  8'hFF, 1'b1, 1'b0, 8'h00, 16'hA577};
    vecs[12] = '{4'd5,  8'h00, 1'b0, 1'b1, mask_exp, 16'hA577};

    rst = 1'b1; addr = '0; wdata = '0; wr_en = 1'b0; rd_en = 1'b0; sw_in = '0;
    repeat (2) @(negedge clock);
    check("reset led_out", 32'(led_out), 32'h0);
    check("reset rvalid", 32'(rvalid), 32'h0);
    check("reset rdata", 32'(rdata), 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    rst = 1'b0;

    // Asynchronous reset arriving with a read in flight.
    write_reg(4'd0, 8'h11);
    check("pre-reset led_out", 32'(led_out), 32'h0011);
    addr  = 4'd0;
    rd_en = 1'b1;
    #2 rst = 1'b1;
    #1 check("async reset led_out", 32'(led_out), 32'h0);
    @(posedge clock);
    @(negedge clock);
    check("mid-read reset rvalid", 32'(rvalid), 32'h0);
    check("mid-read reset rdata", 32'(rdata), 32'h0);
    rd_en = 1'b0;
    rst   = 1'b0;
    read_check("status after reset", 4'd4, 8'h00);

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i], i);
      if (vecs[i].rd) last_rd = vecs[i].exp_rdata;
    end
    write_reg(4'd5, 8'h00);
    check("rvalid single cycle", 32'(rvalid), 32'h0);
    check("rdata held", 32'(rdata), 32'(last_rd));

    // Port 0 change: update lands on the 6th edge after the raw change.
    sw_in[7:0] = 8'h3C;
    repeat (5) @(posedge clock);
    @(negedge clock);
    addr  = 4'd2;
    rd_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("IN0 before edge 6", 32'(rdata), 32'h00);
    @(posedge clock);
    @(negedge clock);
    rd_en = 1'b0;
    check("IN0 at edge 6", 32'(rdata), 32'h3C);
    read_check("status port0", 4'd4, 8'h01);

    // Two-cycle glitch must be filtered.
    sw_in[7:0] = 8'hFF;
    repeat (2) @(negedge clock);
    sw_in[7:0] = 8'h3C;
    repeat (10) @(negedge clock);
    read_check("IN0 after glitch", 4'd2, 8'h3C);
    read_check("status after glitch", 4'd4, 8'h01);

    sw_in[15:8] = 8'h11;
    repeat (10) @(negedge clock);
    read_check("IN1", 4'd3, 8'h11);
    read_check("status both", 4'd4, 8'h03);
    write_reg(4'd4, 8'h01);
    read_check("status w1c bit0", 4'd4, 8'h02);
    write_reg(4'd4, 8'h03);
    read_check("status cleared", 4'd4, 8'h00);

    // Set and clear of bit 1 on the same edge: set wins.
    sw_in[15:8] = 8'h22;
    repeat (5) @(posedge clock);
    @(negedge clock);
    write_reg(4'd4, 8'h02);
    read_check("set beats clear", 4'd4, 8'h02);
    read_check("IN1 updated", 4'd3, 8'h22);
    write_reg(4'd4, 8'h03);

`ifdef IO_PORT_BANK_IRQ_EN
    write_reg(4'd5, 8'h02);
    read_check("mask readback", 4'd5, 8'h02);
    repeat (2) @(negedge clock);
    check("irq idle", 32'(irq), 32'h0);
    sw_in[7:0] = 8'h44;
    repeat (10) @(negedge clock);
    check("irq masked port0", 32'(irq), 32'h0);
    sw_in[15:8] = 8'h33;
    repeat (10) @(negedge clock);
    check("irq port1", 32'(irq), 32'h1);
    write_reg(4'd4, 8'h02);
    repeat (2) @(negedge clock);
    check("irq cleared", 32'(irq), 32'h0);
`else
    write_reg(4'd5, 8'h02);
    read_check("mask reads zero", 4'd5, 8'h00);
    sw_in[15:8] = 8'h33;
    repeat (10) @(negedge clock);
    check("irq tied low", 32'(irq), 32'h0);
    read_check("status polling", 4'd4, 8'h02);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
